// File: rtl/vga_fill_if.sv
// rtl/vga_fill_if.sv - command and pixel-output bundle for vga_fill; out_stall exists only with VGA_FILL_STALL_EN
interface vga_fill_if #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_mode;
  logic [X_W-1:0]      cmd_x0;
  logic [X_W-1:0]      cmd_x1;
  logic [Y_W-1:0]      cmd_y0;
  logic [Y_W-1:0]      cmd_y1;
  logic [COLOUR_W-1:0] cmd_colour;
  logic                busy;
  logic                done;
  logic [X_W-1:0]      out_x;
  logic [Y_W-1:0]      out_y;
  logic [COLOUR_W-1:0] out_colour;
  logic                out_plot;
`ifdef VGA_FILL_STALL_EN
  logic                out_stall;
`endif

  // Command source and pixel sink side.
  modport master (
    output cmd_valid, cmd_mode, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_colour,
`ifdef VGA_FILL_STALL_EN
    output out_stall,
`endif
    input  cmd_ready, busy, done, out_x, out_y, out_colour, out_plot
  );

  // Draw engine side.
  modport slave (
    input  cmd_valid, cmd_mode, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_colour,
`ifdef VGA_FILL_STALL_EN
    input  out_stall,
`endif
    output cmd_ready, busy, done, out_x, out_y, out_colour, out_plot
  );
endinterface

// File: rtl/vga_fill.sv
// rtl/vga_fill.sv - raster draw engine (pixel/rect/clear) feeding a VGA adapter; optional out_stall via VGA_FILL_STALL_EN
module vga_fill #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input logic       clock,
  input logic       reset,
  vga_fill_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DRAW = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  localparam logic [1:0] MODE_PIXEL = 2'b00;
  localparam logic [1:0] MODE_RECT  = 2'b01;
  localparam logic [1:0] MODE_CLEAR = 2'b10;

  // Last visible column/row, held one bit wider than the coordinates so
  // clipping compares never wrap.
  localparam int XL = SCREEN_W - 1;
  localparam int YL = SCREEN_H - 1;
  localparam logic [X_W:0] X_LAST = XL[X_W:0];
  localparam logic [Y_W:0] Y_LAST = YL[Y_W:0];

  logic [1:0]          state;
  logic [X_W:0]        x_cnt;
  logic [Y_W:0]        y_cnt;
  logic [X_W:0]        xmin_q;
  logic [X_W:0]        xmax_q;
  logic [Y_W:0]        ymax_q;
  logic [COLOUR_W-1:0] colour_q;
  logic                last_q;
  logic [X_W-1:0]      x_q;
  logic [Y_W-1:0]      y_q;
  logic [COLOUR_W-1:0] c_q;
  logic                plot_q;
  logic                done_q;
  logic                stall;

  logic [X_W:0] ax0;
  logic [X_W:0] ax1;
  logic [Y_W:0] ay0;
  logic [Y_W:0] ay1;
  logic [X_W:0] n_xmin;
  logic [X_W:0] n_xmax;
  logic [Y_W:0] n_ymin;
  logic [Y_W:0] n_ymax;
  logic         n_noop;
  logic         n_empty;
  logic         accept;

`ifdef VGA_FILL_STALL_EN
  assign stall = bus.out_stall;
`else
  assign stall = 1'b0;
`endif

  assign accept = (state == IDLE) && bus.cmd_valid;

  assign ax0 = {1'b0, bus.cmd_x0};
  assign ax1 = {1'b0, bus.cmd_x1};
  assign ay0 = {1'b0, bus.cmd_y0};
  assign ay1 = {1'b0, bus.cmd_y1};

  // Normalise the incoming command into an ordered, clipped scan window.
  always_comb begin
    n_xmin = '0;
    n_xmax = '0;
    n_ymin = '0;
    n_ymax = '0;
    n_noop = 1'b0;
    case (bus.cmd_mode)
      MODE_PIXEL: begin
        n_xmin = ax0;
        n_xmax = ax0;
        n_ymin = ay0;
        n_ymax = ay0;
      end
      MODE_RECT: begin
        n_xmin = (ax0 < ax1) ? ax0 : ax1;
        n_xmax = (ax0 < ax1) ? ax1 : ax0;
        n_ymin = (ay0 < ay1) ? ay0 : ay1;
        n_ymax = (ay0 < ay1) ? ay1 : ay0;
      end
      MODE_CLEAR: begin
        n_xmax = X_LAST;
        n_ymax = Y_LAST;
      end
      default: n_noop = 1'b1;
    endcase
    if (n_xmax > X_LAST) n_xmax = X_LAST;
    if (n_ymax > Y_LAST) n_ymax = Y_LAST;
    n_empty = n_noop || (n_xmin > X_LAST) || (n_ymin > Y_LAST);
  end

  // Command FSM, scan counters and registered pixel outputs. An empty
  // command enters DRAW with last_q already set, so it reaches FIN one
  // cycle later without plotting and done lands the cycle after acceptance.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      x_cnt    <= '0;
      y_cnt    <= '0;
      xmin_q   <= '0;
      xmax_q   <= '0;
      ymax_q   <= '0;
      colour_q <= '0;
      last_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      c_q      <= '0;
      plot_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          plot_q <= 1'b0;
          done_q <= 1'b0;
          if (accept) begin
            x_cnt    <= n_xmin;
            y_cnt    <= n_ymin;
            xmin_q   <= n_xmin;
            xmax_q   <= n_xmax;
            ymax_q   <= n_ymax;
            colour_q <= bus.cmd_colour;
            last_q   <= n_empty;
            state    <= DRAW;
          end
        end
        DRAW: begin
          if (last_q) begin
            plot_q <= 1'b0;
            done_q <= 1'b1;
            last_q <= 1'b0;
            state  <= FIN;
          end else if (stall) begin
            plot_q <= 1'b0;
          end else begin
            x_q    <= x_cnt[X_W-1:0];
            y_q    <= y_cnt[Y_W-1:0];
            c_q    <= colour_q;
            plot_q <= 1'b1;
            if (x_cnt == xmax_q) begin
              x_cnt <= xmin_q;
              y_cnt <= y_cnt + 1'b1;
              if (y_cnt == ymax_q) last_q <= 1'b1;
            end else begin
              x_cnt <= x_cnt + 1'b1;
            end
          end
        end
        FIN: begin
          plot_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          plot_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready  = (state == IDLE);
  assign bus.busy       = (state != IDLE);
  assign bus.done       = done_q;
  assign bus.out_x      = x_q;
  assign bus.out_y      = y_q;
  assign bus.out_colour = c_q;
  assign bus.out_plot   = plot_q;

endmodule

// File: tb/tb_vga_fill.sv
// tb/tb_vga_fill.sv - directed self-checking bench for vga_fill
module tb_vga_fill;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vga_fill_if #(.X_W(X_W), .Y_W(Y_W), .COLOUR_W(COLOUR_W)) bus ();

  vga_fill #(.X_W(X_W), .Y_W(Y_W), .COLOUR_W(COLOUR_W), .SCREEN_W(160), .SCREEN_H(120)) dut (
    .clock(clk),
    .reset(rst_n),
    .bus  (bus)
  );

  int vectors = 0;
  int errors  = 0;

  int   qx[$];
  int   qy[$];
  int   qc[$];
  int   qcyc[$];
  int   done_c;
  int   done_n;
  logic ready_at_done;
  logic ready_after;

  task automatic drive_fields(input logic [1:0] m, input int x0, input int x1,
                              input int y0, input int y1, input int c);
    bus.cmd_mode   = m;
    bus.cmd_x0     = x0[X_W-1:0];
    bus.cmd_x1     = x1[X_W-1:0];
    bus.cmd_y0     = y0[Y_W-1:0];
    bus.cmd_y1     = y1[Y_W-1:0];
    bus.cmd_colour = c[COLOUR_W-1:0];
  endtask

  // Present one command from idle; returns just after the accepting edge.
  task automatic send(input logic [1:0] m, input int x0, input int x1,
                      input int y0, input int y1, input int c);
    @(negedge clk);
    drive_fields(m, x0, x1, y0, y1, c);
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Record plots (cycle 0 = the cycle right after acceptance) until done, bounded.
  task automatic collect(input int limit);
    qx.delete(); qy.delete(); qc.delete(); qcyc.delete();
    done_c = -1;
    done_n = 0;
    ready_at_done = 1'bx;
    ready_after   = 1'bx;
    for (int c = 0; c <= limit; c++) begin
      @(negedge clk);
      if (bus.out_plot) begin
        qx.push_back(int'(bus.out_x));
        qy.push_back(int'(bus.out_y));
        qc.push_back(int'(bus.out_colour));
        qcyc.push_back(c);
      end
      if (bus.done) begin
        done_n++;
        if (done_c < 0) begin
          done_c = c;
          ready_at_done = bus.cmd_ready;
        end
      end
      if (done_c >= 0 && c == done_c + 1) begin
        ready_after = bus.cmd_ready;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    vectors++;
    if ({bus.cmd_ready, bus.busy, bus.done, bus.out_plot} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctrl got=%b want=1000", {bus.cmd_ready, bus.busy, bus.done, bus.out_plot});
    end
    vectors++;
    if ({bus.out_x, bus.out_y, bus.out_colour} !== '0) begin
      errors++;
      $display("FAIL reset_data got x=%0d y=%0d c=%0d want 0,0,0", bus.out_x, bus.out_y, bus.out_colour);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got=%b want=1", bus.cmd_ready);
    end
  endtask

  task automatic test_pixel;
    send(2'b00, 5, 0, 7, 0, 3);
    collect(10);
    vectors++;
    if (qx.size() !== 1) begin
      errors++;
      $display("FAIL pixel_count got=%0d want=1", qx.size());
    end else begin
      vectors++;
      if (qx[0] !== 5 || qy[0] !== 7 || qc[0] !== 3 || qcyc[0] !== 1) begin
        errors++;
        $display("FAIL pixel_data got (%0d,%0d,%0d)@%0d want (5,7,3)@1", qx[0], qy[0], qc[0], qcyc[0]);
      end
    end
    vectors++;
    if (done_c !== 2 || done_n !== 1) begin
      errors++;
      $display("FAIL pixel_done got cycle=%0d n=%0d want cycle=2 n=1", done_c, done_n);
    end
    vectors++;
    if ({ready_at_done, ready_after} !== 2'b01) begin
      errors++;
      $display("FAIL pixel_ready got=%b%b want=01", ready_at_done, ready_after);
    end
  endtask

  task automatic test_rect_order;
    int ex[6] = '{8, 9, 10, 8, 9, 10};
    int ey[6] = '{2, 2, 2, 3, 3, 3};
    int bad = 0;
    send(2'b01, 10, 8, 2, 3, 5);
    collect(20);
    vectors++;
    if (qx.size() !== 6) begin
      errors++;
      $display("FAIL rect_count got=%0d want=6", qx.size());
    end else begin
      for (int i = 0; i < 6; i++)
        if (qx[i] != ex[i] || qy[i] != ey[i] || qc[i] != 5 || qcyc[i] != i + 1) bad++;
      vectors++;
      if (bad !== 0) begin
        errors++;
        $display("FAIL rect_order got %0d bad pixels want 0 (first got (%0d,%0d))", bad, qx[0], qy[0]);
      end
    end
    vectors++;
    if (done_c !== 7 || ready_after !== 1'b1) begin
      errors++;
      $display("FAIL rect_done got cycle=%0d ready=%b want cycle=7 ready=1", done_c, ready_after);
    end
  endtask

  task automatic test_clear;
    int bad = 0;
    send(2'b10, 0, 0, 0, 0, 0);
    collect(20000);
    vectors++;
    if (qx.size() !== 19200) begin
      errors++;
      $display("FAIL clear_count got=%0d want=19200", qx.size());
    end else begin
      for (int i = 0; i < 19200; i++)
        if (qcyc[i] != i + 1 || qc[i] != 0 || qx[i] != i % 160 || qy[i] != i / 160) bad++;
      vectors++;
      if (bad !== 0) begin
        errors++;
        $display("FAIL clear_scan got %0d bad pixels want 0", bad);
      end
      vectors++;
      if (qx[19199] !== 159 || qy[19199] !== 119) begin
        errors++;
        $display("FAIL clear_last got (%0d,%0d) want (159,119)", qx[19199], qy[19199]);
      end
    end
    vectors++;
    if (done_c !== 19201) begin
      errors++;
      $display("FAIL clear_done got=%0d want=19201", done_c);
    end
  endtask

  task automatic test_clip;
    send(2'b01, 150, 200, 115, 127, 6);
    collect(100);
    vectors++;
    if (qx.size() !== 50) begin
      errors++;
      $display("FAIL clip_count got=%0d want=50", qx.size());
    end else begin
      vectors++;
      if (qx[0] !== 150 || qy[0] !== 115 || qx[49] !== 159 || qy[49] !== 119 || qc[49] !== 6) begin
        errors++;
        $display("FAIL clip_corners got (%0d,%0d)..(%0d,%0d) want (150,115)..(159,119)", qx[0], qy[0], qx[49], qy[49]);
      end
    end
    vectors++;
    if (done_c !== 51) begin
      errors++;
      $display("FAIL clip_done got=%0d want=51", done_c);
    end
  endtask

  task automatic test_empty;
    send(2'b01, 170, 170, 0, 5, 2);
    collect(10);
    vectors++;
    if (qx.size() !== 0 || done_c !== 1 || ready_at_done !== 1'b0 || ready_after !== 1'b1) begin
      errors++;
      $display("FAIL empty_offscreen got plots=%0d done=%0d ready=%b%b want 0,1,01", qx.size(), done_c, ready_at_done, ready_after);
    end
    send(2'b11, 3, 4, 3, 4, 1);
    collect(10);
    vectors++;
    if (qx.size() !== 0 || done_c !== 1 || ready_after !== 1'b1) begin
      errors++;
      $display("FAIL empty_noop got plots=%0d done=%0d ready=%b want 0,1,1", qx.size(), done_c, ready_after);
    end
  endtask

  task automatic test_reset_mid;
    int n = 0;
    int d = 0;
    send(2'b10, 0, 0, 0, 0, 1);
    for (int c = 0; c < 300 && n < 100; c++) begin
      @(negedge clk);
      if (bus.out_plot) n++;
    end
    vectors++;
    if (n !== 100) begin
      errors++;
      $display("FAIL midreset_preplots got=%0d want=100", n);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.out_plot, bus.busy, bus.done, bus.cmd_ready} !== 4'b0001 || bus.out_x !== '0) begin
      errors++;
      $display("FAIL midreset_async got plot/busy/done/ready=%b x=%0d want 0001 x=0",
               {bus.out_plot, bus.busy, bus.done, bus.cmd_ready}, bus.out_x);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.done) d++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.done || bus.out_plot) d++;
    end
    vectors++;
    if (d !== 0 || bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_after got stray=%0d ready=%b want 0 1", d, bus.cmd_ready);
    end
    send(2'b00, 9, 0, 11, 0, 4);
    collect(10);
    vectors++;
    if (qx.size() !== 1 || done_c !== 2) begin
      errors++;
      $display("FAIL midreset_pixel_count got plots=%0d done=%0d want 1 2", qx.size(), done_c);
    end else begin
      vectors++;
      if (qx[0] !== 9 || qy[0] !== 11 || qc[0] !== 4) begin
        errors++;
        $display("FAIL midreset_pixel got (%0d,%0d,%0d) want (9,11,4)", qx[0], qy[0], qc[0]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int acc_c = -1;
    int dq[$];
    int ex[4] = '{1, 2, 3, 20};
    int ey[4] = '{2, 2, 2, 30};
    int ec[4] = '{2, 2, 2, 7};
    int ecy[4] = '{1, 2, 3, 7};
    int bad = 0;
    qx.delete(); qy.delete(); qc.delete(); qcyc.delete();
    @(negedge clk);
    drive_fields(2'b01, 1, 3, 2, 2, 2);
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c <= 12; c++) begin
      if (c == 0) drive_fields(2'b01, 50, 60, 10, 20, 1);
      if (c == 3) drive_fields(2'b00, 20, 0, 30, 0, 7);
      @(negedge clk);
      if (bus.out_plot) begin
        qx.push_back(int'(bus.out_x));
        qy.push_back(int'(bus.out_y));
        qc.push_back(int'(bus.out_colour));
        qcyc.push_back(c);
      end
      if (bus.done) dq.push_back(c);
      if (acc_c >= 0 && c == acc_c + 1) bus.cmd_valid = 1'b0;
      if (bus.cmd_ready && acc_c < 0) acc_c = c;
    end
    bus.cmd_valid = 1'b0;
    vectors++;
    if (acc_c !== 5) begin
      errors++;
      $display("FAIL b2b_accept got ready cycle=%0d want=5", acc_c);
    end
    vectors++;
    if (qx.size() !== 4) begin
      errors++;
      $display("FAIL b2b_count got=%0d want=4", qx.size());
    end else begin
      for (int i = 0; i < 4; i++)
        if (qx[i] != ex[i] || qy[i] != ey[i] || qc[i] != ec[i] || qcyc[i] != ecy[i]) bad++;
      vectors++;
      if (bad !== 0) begin
        errors++;
        $display("FAIL b2b_pixels got %0d bad pixels want 0 (last got (%0d,%0d,%0d)@%0d)", bad, qx[3], qy[3], qc[3], qcyc[3]);
      end
    end
    vectors++;
    if (dq.size() !== 2 || dq[0] !== 4 || dq[1] !== 8) begin
      errors++;
      $display("FAIL b2b_done got n=%0d want done at cycles 4 and 8", dq.size());
    end
  endtask

`ifdef VGA_FILL_STALL_EN
  task automatic test_stall;
    int st = -1;
    int bad = 0;
    send(2'b01, 40, 43, 10, 10, 1);
    qx.delete(); qy.delete(); qc.delete(); qcyc.delete();
    done_c = -1;
    for (int c = 0; c <= 15; c++) begin
      @(negedge clk);
      if (bus.out_plot) begin
        qx.push_back(int'(bus.out_x));
        qy.push_back(int'(bus.out_y));
        qcyc.push_back(c);
      end
      if (bus.done && done_c < 0) done_c = c;
      if (st >= 0 && c == st + 3) bus.out_stall = 1'b0;
      if (st < 0 && qx.size() == 2) begin
        st = c;
        bus.out_stall = 1'b1;
      end
    end
    bus.out_stall = 1'b0;
    vectors++;
    if (qx.size() !== 4) begin
      errors++;
      $display("FAIL stall_count got=%0d want=4", qx.size());
    end else begin
      for (int i = 0; i < 4; i++)
        if (qx[i] != 40 + i || qy[i] != 10) bad++;
      vectors++;
      if (bad !== 0 || qcyc[3] - qcyc[0] + 1 !== 7) begin
        errors++;
        $display("FAIL stall_span got bad=%0d span=%0d want bad=0 span=7", bad, qcyc[3] - qcyc[0] + 1);
      end
    end
    vectors++;
    if (done_c !== 8) begin
      errors++;
      $display("FAIL stall_done got=%0d want=8", done_c);
    end
  endtask
`endif

  initial begin
    bus.cmd_valid = 1'b0;
    drive_fields(2'b00, 0, 0, 0, 0, 0);
`ifdef VGA_FILL_STALL_EN
    bus.out_stall = 1'b0;
`endif
    test_reset;
    test_pixel;
    test_rect_order;
    test_clear;
    test_clip;
    test_empty;
    test_reset_mid;
    test_back_to_back;
`ifdef VGA_FILL_STALL_EN
    test_stall;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
